// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bus between the four mux requesters and mux_sel_arbiter.
// master: requester side; slave: arbiter side.
interface mux_sel_arbiter_if;
  logic [3:0] req;
  logic [3:0] done;
  logic [3:0] gnt;
  logic       gnt_vld;
  logic [3:0] sel;
  logic [1:0] gnt_id;
  logic       to_flag;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_vld,
    input  sel,
    input  gnt_id,
    input  to_flag
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_vld,
    output sel,
    output gnt_id,
    output to_flag
  );
endinterface

// File: rtl/mux_sel_arbiter.sv
// Round-robin owner arbiter driving the always-one-hot select of the shared 4-input mux.
// Optional forced release after MAX_HOLD cycles: define MUX_SEL_ARB_TIMEOUT_EN.
module mux_sel_arbiter #(
  parameter int unsigned INIT_PTR = 0,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic                i_clk,
  input  logic                i_rst,
  mux_sel_arbiter_if.slave    io_bus
);

  typedef enum logic {StIdle, StOwn} state_e;

  localparam logic [1:0]       InitPtr  = 2'(INIT_PTR);
  localparam logic [CNT_W-1:0] CntMax   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(MAX_HOLD - 1);

  function automatic logic [3:0] onehot(input logic [1:0] id);
    return 4'b0001 << id;
  endfunction

  // Descending scan so the smallest offset from ptr is assigned last and wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] win;
    win = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (cand[idx]) win = idx;
    end
    return win;
  endfunction

  state_e           r_state;
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_gnt;
  logic             r_gnt_vld;
  logic [3:0]       r_sel;
  logic [1:0]       r_gnt_id;
  logic             r_to_flag;

  logic       w_own;
  logic [3:0] w_owner_bit;
  logic       w_natural;
  logic       w_hold_hit;
  logic       w_forced;
  logic       w_release;
  logic [3:0] w_cand;
  logic [1:0] w_ptr;
  logic [1:0] w_winner;

  // While owning, r_gnt_id is the owner index.
  assign w_own       = (r_state == StOwn);
  assign w_owner_bit = onehot(r_gnt_id);
  assign w_natural   = w_own && (((io_bus.done & w_owner_bit) != 4'b0000) ||
                                 ((io_bus.req & w_owner_bit) == 4'b0000));
  assign w_hold_hit  = (r_cnt >= HoldLast);

`ifdef MUX_SEL_ARB_TIMEOUT_EN
  assign w_forced = w_own && w_hold_hit && !w_natural;
`else
  logic w_unused_hold;
  assign w_unused_hold = w_hold_hit;
  assign w_forced      = 1'b0;
`endif

  assign w_release = w_natural || w_forced;
  assign w_cand    = w_own ? (io_bus.req & ~w_owner_bit) : io_bus.req;
  assign w_ptr     = w_own ? (r_gnt_id + 2'd1) : r_ptr;
  assign w_winner  = rr_pick(w_cand, w_ptr);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_ptr     <= InitPtr;
      r_cnt     <= '0;
      r_gnt     <= 4'b0000;
      r_gnt_vld <= 1'b0;
      r_sel     <= onehot(InitPtr);
      r_gnt_id  <= InitPtr;
      r_to_flag <= 1'b0;
    end else begin
      r_to_flag <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (|w_cand) begin
            r_state   <= StOwn;
            r_gnt     <= onehot(w_winner);
            r_gnt_vld <= 1'b1;
            r_sel     <= onehot(w_winner);
            r_gnt_id  <= w_winner;
            r_cnt     <= '0;
          end
        end
        StOwn: begin
          if (w_release) begin
            r_ptr     <= w_ptr;
            r_to_flag <= w_forced;
            r_cnt     <= '0;
            if (|w_cand) begin
              r_gnt    <= onehot(w_winner);
              r_sel    <= onehot(w_winner);
              r_gnt_id <= w_winner;
            end else begin
              // SEL and GNT_ID keep pointing at the old owner so the mux never sees 0.
              r_state   <= StIdle;
              r_gnt     <= 4'b0000;
              r_gnt_vld <= 1'b0;
            end
          end else if (r_cnt != CntMax) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign io_bus.gnt     = r_gnt;
  assign io_bus.gnt_vld = r_gnt_vld;
  assign io_bus.sel     = r_sel;
  assign io_bus.gnt_id  = r_gnt_id;
  assign io_bus.to_flag = r_to_flag;

endmodule

// File: doc/mux_sel_arbiter.md
Name: mux_sel_arbiter

Overview:
- Round-robin arbiter that shares the 4-input one-hot-select mux in the single-cycle processor datapath among four requesters.
- Produces the registered one-hot SEL that drives the mux, plus grant and status outputs.
- Guarantees SEL is always exactly one-hot, because the mux has no default arm and must never see 0 or a multi-hot code.
- Owner holds the mux until it signals DONE or drops REQ. Back-to-back handover has zero idle cycles.

Parameters:
- INIT_PTR, 0: index (0..3) of the highest-priority requester after reset.
- MAX_HOLD, 16: maximum grant length in cycles. Used only with MUX_SEL_ARB_TIMEOUT_EN. Legal range is 1..2^CNT_W-1.
- CNT_W, 5: width of the hold counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset, synchronous and active-high.
- REQ  input  4  per-requester request level; bit i belongs to requester i.
- DONE  input  4  per-requester end-of-transaction pulse. Only the owner's bit is honoured.
- GNT  output  4  one-hot grant, or 0 when nobody owns the mux.
- GNT_VLD  output  1  1 when GNT is nonzero.
- SEL  output  4  mux select. Always one-hot.
- GNT_ID  output  2  binary index of SEL.
- TO_FLAG  output  1  one-cycle pulse on forced release (timeout feature only).

Behaviour:
- All outputs are registered.
- Reset values: GNT=0, GNT_VLD=0, SEL=one-hot(INIT_PTR), GNT_ID=INIT_PTR, TO_FLAG=0. Internal state: state=IDLE, PTR=INIT_PTR, hold counter=0.
- RST mid-operation aborts the current ownership at that edge. No handover occurs and DONE is ignored.

State IDLE:
- At an edge with REQ≠0, pick the winner W: the first set bit in search order PTR, PTR+1, ... mod 4.
- That edge sets GNT=one-hot(W), SEL=one-hot(W), GNT_ID=W, state=OWN. Grant latency is 1 cycle from the sampling edge.
- REQ=0: remain in IDLE; SEL/GNT_ID hold their last value.

State OWN (owner O):
- Release condition: DONE[O]=1 or REQ[O]=0 at the edge. Otherwise O keeps the grant and GNT/SEL are stable.
- On release:
  - PTR becomes O+1 mod 4.
  - Candidates are REQ with bit O masked.
  - If any candidate exists, grant the round-robin winner from the new PTR at the same edge. GNT changes directly from O to the new owner with no zero cycle.
  - If no candidate: GNT=0, GNT_VLD=0, state=IDLE; SEL/GNT_ID hold O.
  - O re-requesting is served from IDLE one cycle later, or after the others in the rotation.
- Non-owner DONE bits are ignored in every state. Non-owner REQ changes have no effect until the next arbitration edge.
- DONE[O] and REQ[O]=0 in the same cycle count as a single release.

Invariants:
- popcount(SEL)=1 in every cycle, including during reset.
- GNT is 0 or equal to SEL.
- GNT_VLD = |GNT.
- The hold counter clears on every new grant and counts cycles of the current ownership, saturating at 2^CNT_W-1.

Optional Feature:
- Macro: MUX_SEL_ARB_TIMEOUT_EN.
- Defined: when the hold counter shows the owner has held GNT for MAX_HOLD cycles, the next edge performs a forced release exactly as if DONE[O]=1 (same PTR update and same-edge handover). TO_FLAG=1 for that one cycle.
- Undefined: counter timeout logic is absent, ownership is unbounded, and TO_FLAG is tied to 0.
- Port list is identical in both builds.

Test Plan:
- Reset: assert RST 2 cycles with REQ=1111 (INIT_PTR=0) → GNT=0000, GNT_VLD=0, SEL=0001, GNT_ID=0. First grant after RST drops is 0001.
- Single requester: REQ=0100 from IDLE → next cycle GNT=0100, SEL=0100, GNT_ID=2. Pulse DONE[2] with REQ=0100 → next cycle GNT=0000, SEL stays 0100. One cycle later GNT=0100 again.
- Full load: REQ=1111 held, each owner pulses DONE on its 2nd grant cycle → grant order 0,1,2,3,0, GNT never 0 between owners, SEL one-hot every cycle.
- Non-owner noise: owner 1 with REQ=1010, pulse DONE[3] → no change. Drop REQ[1] → next cycle GNT=1000, GNT_ID=3.
- Reset mid-ownership: owner 2, assert RST 1 cycle → GNT=0, SEL=0001. Then REQ=1100 → grant 2 (PTR back at 0).
- Timeout (macro defined, MAX_HOLD=4): REQ=0011 held, no DONE → GNT=0001 for exactly 4 cycles, TO_FLAG pulses on the release edge, GNT=0010 the same edge. Macro undefined: GNT=0001 held for 50+ cycles, TO_FLAG=0.
